// File: rtl/score_pkg.sv
// Shared constants, hand state encoding and the card-to-point mapping used by
// the hand accumulator and its per-hand lanes.
package score_pkg;

   localparam int CARD_ACE    = 1;
   localparam int FACE_MIN    = 10;
   localparam int CARD_MAX    = 13;
   localparam int MOD         = 10;
   localparam int NATURAL_MIN = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2,
      FULL  = 2'd3
   } hand_state_t;

   typedef struct packed {
      logic       illegal;
      logic [3:0] value;
   } card_val_t;

   // Codes outside ace..king still occupy a card slot but contribute no points.
   function automatic card_val_t card_value(input logic [7:0] code,
                                            input int face_min = FACE_MIN);
      card_val_t res;
      res.illegal = (int'(code) < CARD_ACE) || (int'(code) > CARD_MAX);
      if (res.illegal || (int'(code) >= face_min)) begin
         res.value = 4'd0;
      end else begin
         res.value = code[3:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/score_accum_if.sv
// Dealer-to-accumulator card handshake: one card per cycle, steered by hand_sel.
interface score_accum_if #(
   parameter int CARD_W = 4,
   parameter int SEL_W  = 1
);
   logic              card_valid;
   logic [CARD_W-1:0] card;
   logic [SEL_W-1:0]  hand_sel;
   logic              card_ready;

   modport master (
      output card_valid,
      output card,
      output hand_sel,
      input  card_ready
   );

   modport slave (
      input  card_valid,
      input  card,
      input  hand_sel,
      output card_ready
   );
endinterface

// File: rtl/score_lane.sv
// One hand channel: running modulo score, card count, occupancy state and the
// two-card natural flag, all updated together on an accepted card.
module score_lane #(
   parameter int MAX_CARDS = 3,
   parameter int MOD       = 10
) (
   input  logic       slow_clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       accept,
   input  logic [3:0] value,
   output logic [3:0] total,
   output logic [1:0] count,
   output logic       full,
   output logic       natural
);
   import score_pkg::*;

   hand_state_t state;

   logic [4:0]  sum;
   logic [3:0]  next_total;
   logic [1:0]  next_count;
   logic        next_full;
   logic        next_natural;
   hand_state_t next_state;

   // Both operands stay below MOD, so one conditional subtract wraps the sum.
   always_comb begin
      sum          = {1'b0, total} + {1'b0, value};
      next_total   = sum[3:0];
      if (sum >= 5'(MOD)) begin
         next_total = 4'(sum - 5'(MOD));
      end
      next_count   = count + 2'd1;
      next_full    = (next_count == 2'(MAX_CARDS));
      next_natural = (next_count == 2'd2) && (next_total >= 4'(NATURAL_MIN));
      next_state   = next_full ? FULL : hand_state_t'(next_count);
   end

   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         state   <= EMPTY;
         total   <= 4'd0;
         count   <= 2'd0;
         full    <= 1'b0;
         natural <= 1'b0;
      end else if (clear) begin
         state   <= EMPTY;
         total   <= 4'd0;
         count   <= 2'd0;
         full    <= 1'b0;
         natural <= 1'b0;
      end else if (accept && (state != FULL)) begin
         state   <= next_state;
         total   <= next_total;
         count   <= next_count;
         full    <= next_full;
         natural <= next_natural;
      end
   end

endmodule

// File: rtl/score_accum.sv
// Multi-hand score accumulator: steers each offered card to its hand lane and
// keeps the ready, score_valid and sticky error bookkeeping shared by all hands.
module score_accum #(
   parameter int N_HANDS   = 2,
   parameter int MAX_CARDS = 3,
   parameter int CARD_W    = 4,
   parameter int MOD       = 10,
   parameter int FACE_MIN  = 10,
   localparam int SEL_W    = (N_HANDS > 1) ? $clog2(N_HANDS) : 1
) (
   input  logic                 slow_clock,
   input  logic                 reset,
   input  logic                 clear,
   score_accum_if.slave         bus,
   output logic                 score_valid,
   output logic [N_HANDS*4-1:0] total,
   output logic [N_HANDS*2-1:0] count,
   output logic [N_HANDS-1:0]   full,
   output logic [N_HANDS-1:0]   natural,
   output logic                 err
);
   import score_pkg::*;

   logic [CARD_W-1:0]  card_code;
   logic [7:0]         card_ext;
   logic [SEL_W-1:0]   sel;
   card_val_t          cv;
   logic               sel_ok;
   logic               full_sel;
   logic               accept;
   logic               err_event;
   logic [N_HANDS-1:0] lane_accept;

   assign card_code = bus.card;
   assign card_ext  = 8'(card_code);
   assign sel       = bus.hand_sel;
   assign cv        = card_value(card_ext, FACE_MIN);
   assign sel_ok    = (int'(sel) < N_HANDS);

   always_comb begin
      full_sel = 1'b0;
      for (int h = 0; h < N_HANDS; h++) begin
         if (int'(sel) == h) begin
            full_sel = full[h];
         end
      end
   end

   assign bus.card_ready = sel_ok && !full_sel && !clear;
   assign accept         = bus.card_valid && bus.card_ready;

   // A clear swallows whatever card arrives with it, so it never raises an error.
   assign err_event = bus.card_valid && !clear &&
                      (!sel_ok || full_sel || cv.illegal);

   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         score_valid <= 1'b0;
         err         <= 1'b0;
      end else begin
         score_valid <= accept;
         err         <= err_event | (err & ~clear);
      end
   end

   for (genvar h = 0; h < N_HANDS; h++) begin : g_lane
      assign lane_accept[h] = accept && (int'(sel) == h);

      score_lane #(
         .MAX_CARDS (MAX_CARDS),
         .MOD       (MOD)
      ) u_lane (
         .slow_clock (slow_clock),
         .reset      (reset),
         .clear      (clear),
         .accept     (lane_accept[h]),
         .value      (cv.value),
         .total      (total[4*h +: 4]),
         .count      (count[2*h +: 2]),
         .full       (full[h]),
         .natural    (natural[h])
      );
   end

endmodule

// File: tb/tb_score_accum.sv
// Directed bench for score_accum: hand-computed scenarios followed by a
// two-card sweep over every legal card pair on each hand.
module tb_score_accum;

   logic       slow_clock;
   logic       reset;
   logic       clear;
   logic       score_valid;
   logic [7:0] total;
   logic [3:0] count;
   logic [1:0] full;
   logic [1:0] natural;
   logic       err;

   int compared   = 0;
   int mismatched = 0;

   score_accum_if #(.CARD_W(4), .SEL_W(1)) bus ();

   score_accum #(
      .N_HANDS   (2),
      .MAX_CARDS (3),
      .CARD_W    (4),
      .MOD       (10),
      .FACE_MIN  (10)
   ) dut (
      .slow_clock  (slow_clock),
      .reset       (reset),
      .clear       (clear),
      .bus         (bus),
      .score_valid (score_valid),
      .total       (total),
      .count       (count),
      .full        (full),
      .natural     (natural),
      .err         (err)
   );

   initial begin
      slow_clock = 1'b0;
      forever #5 slow_clock = ~slow_clock;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Present one cycle of inputs, clock it in, then return to idle 1 ns after the edge.
   task automatic applyStimulus(input logic valid, input logic sel,
                                input logic [3:0] code, input logic clr);
      bus.card_valid = valid;
      bus.hand_sel   = sel;
      bus.card       = code;
      clear          = clr;
      @(posedge slow_clock);
      #1;
      bus.card_valid = 1'b0;
      clear          = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_total"}, int'(total), 0);
      checkOutput({tag, "_count"}, int'(count), 0);
      checkOutput({tag, "_full"}, int'(full), 0);
      checkOutput({tag, "_natural"}, int'(natural), 0);
      checkOutput({tag, "_err"}, int'(err), 0);
      checkOutput({tag, "_score_valid"}, int'(score_valid), 0);
   endtask

   function automatic int card_points(input int code);
      return (code >= 10) ? 0 : code;
   endfunction

   initial begin
      reset          = 1'b1;
      clear          = 1'b0;
      bus.card_valid = 1'b0;
      bus.card       = 4'd0;
      bus.hand_sel   = 1'b0;
      #2;
      checkAllZero("reset");
      @(posedge slow_clock);
      #1;
      reset = 1'b0;

      // Wrap-around and face cards on hand 0: 9, king, 8.
      applyStimulus(1'b1, 1'b0, 4'd9, 1'b0);
      checkOutput("wrap1_total", int'(total[3:0]), 9);
      checkOutput("wrap1_count", int'(count[1:0]), 1);
      checkOutput("wrap1_sv", int'(score_valid), 1);
      applyStimulus(1'b1, 1'b0, 4'd13, 1'b0);
      checkOutput("wrap2_total", int'(total[3:0]), 9);
      checkOutput("wrap2_count", int'(count[1:0]), 2);
      checkOutput("wrap2_natural", int'(natural[0]), 1);
      checkOutput("wrap2_full", int'(full[0]), 0);
      applyStimulus(1'b1, 1'b0, 4'd8, 1'b0);
      checkOutput("wrap3_total", int'(total[3:0]), 7);
      checkOutput("wrap3_count", int'(count[1:0]), 3);
      checkOutput("wrap3_full", int'(full[0]), 1);
      checkOutput("wrap3_natural", int'(natural[0]), 0);
      checkOutput("wrap3_sv", int'(score_valid), 1);

      // Fill hand 1 with 1, 2, 3 (total 6), then overflow it with a 4.
      applyStimulus(1'b1, 1'b1, 4'd1, 1'b0);
      checkOutput("idle_sv_after_h0", int'(score_valid), 1);
      applyStimulus(1'b1, 1'b1, 4'd2, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'd3, 1'b0);
      checkOutput("fill_h1_total", int'(total[7:4]), 6);
      checkOutput("fill_h1_full", int'(full[1]), 1);
      checkOutput("fill_err", int'(err), 0);
      bus.card_valid = 1'b1;
      bus.hand_sel   = 1'b1;
      bus.card       = 4'd4;
      #1;
      checkOutput("ovf_ready", int'(bus.card_ready), 0);
      applyStimulus(1'b1, 1'b1, 4'd4, 1'b0);
      checkOutput("ovf_err", int'(err), 1);
      checkOutput("ovf_sv", int'(score_valid), 0);
      checkOutput("ovf_h1_total", int'(total[7:4]), 6);
      checkOutput("ovf_h1_count", int'(count[3:2]), 3);
      checkOutput("ovf_h0_total", int'(total[3:0]), 7);
      checkOutput("ovf_h0_count", int'(count[1:0]), 3);

      // Clear together with a card: card dropped, error cleared.
      bus.card_valid = 1'b1;
      bus.hand_sel   = 1'b0;
      bus.card       = 4'd6;
      clear          = 1'b1;
      #1;
      checkOutput("clr_ready", int'(bus.card_ready), 0);
      applyStimulus(1'b1, 1'b0, 4'd6, 1'b1);
      checkAllZero("clr_card");

      // Illegal codes on an empty hand still count as cards.
      applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      checkOutput("ill0_err", int'(err), 1);
      checkOutput("ill0_count", int'(count[1:0]), 1);
      checkOutput("ill0_sv", int'(score_valid), 1);
      applyStimulus(1'b1, 1'b0, 4'd15, 1'b0);
      checkOutput("ill15_count", int'(count[1:0]), 2);
      checkOutput("ill15_total", int'(total[3:0]), 0);
      checkOutput("ill15_err", int'(err), 1);
      checkOutput("ill15_natural", int'(natural[0]), 0);
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
      checkAllZero("clr_only");

      // Reset asserted between edges mid-round: 7 + 5 leaves total 2.
      applyStimulus(1'b1, 1'b0, 4'd7, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd5, 1'b0);
      checkOutput("mid_total", int'(total[3:0]), 2);
      checkOutput("mid_count", int'(count[1:0]), 2);
      #3;
      reset = 1'b1;
      #1;
      checkAllZero("async_reset");
      #2;
      reset = 1'b0;

      // Every legal two-card hand on each channel, back-to-back.
      for (int h = 0; h < 2; h++) begin
         for (int a = 1; a <= 13; a++) begin
            for (int b = 1; b <= 13; b++) begin
               int exp_total;
               exp_total = (card_points(a) + card_points(b)) % 10;
               applyStimulus(1'b0, 1'(h), 4'd0, 1'b1);
               checkOutput("sweep_sv_idle", int'(score_valid), 0);
               applyStimulus(1'b1, 1'(h), 4'(a), 1'b0);
               checkOutput("sweep_sv_a", int'(score_valid), 1);
               applyStimulus(1'b1, 1'(h), 4'(b), 1'b0);
               checkOutput("sweep_sv_b", int'(score_valid), 1);
               checkOutput("sweep_total", int'(total[4*h +: 4]), exp_total);
               checkOutput("sweep_natural", int'(natural[h]), (exp_total >= 8) ? 1 : 0);
            end
         end
      end
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
      checkOutput("sweep_sv_end", int'(score_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
